// File: rtl/alu_issue_stage.sv
// alu_issue_stage: command FIFO in front of a combinational ALU, with a
// registered result/flag output stage. Both sides use valid/ready handshakes.
// The FIFO head drives the ALU inputs directly. A result is captured when the
// FIFO has a command and the output register is empty or being consumed.
// Optional build macro: ALU_ISSUE_STATS_EN adds saturating op/overflow counters
// on stat_ops/stat_ovf. Without it, both ports are tied to zero.
module alu_issue_stage #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [W-1:0]           cmd_a,
  input  logic [W-1:0]           cmd_b,
  input  logic [1:0]             cmd_select,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  output logic [1:0]             alu_select,
  input  logic [W-1:0]           alu_out,
  input  logic                   alu_zero,
  input  logic                   alu_carry,
  input  logic                   alu_sign,
  input  logic                   alu_parity,
  input  logic                   alu_overflow,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [W-1:0]           res_out,
  output logic [4:0]             res_flags,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            stat_ops,
  output logic [15:0]            stat_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   select;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          fire;

  // Pointers carry one extra wrap bit, so the plain difference is the occupancy
  // and full/empty need no separate flag.
  assign fifo_level = wr_ptr - rd_ptr;
  assign cmd_ready  = (fifo_level != FULL_LEVEL);
  assign push       = cmd_valid && cmd_ready;
  assign fire       = (fifo_level != '0) && (!res_valid || res_ready);
  assign head       = mem[rd_ptr[AW-1:0]];

  // Present the head command to the ALU; drive zeros while the FIFO is empty.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    alu_a      = '0;
    alu_b      = '0;
    alu_select = '0;
    if (fifo_level != '0) begin
      alu_a      = head.a;
      alu_b      = head.b;
      alu_select = head.select;
    end
  end

  // Command storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{a: cmd_a, b: cmd_b, select: cmd_select};
    end
  end

  // Advance the write pointer on push and the read pointer on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (fire) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Output stage: capture on fire, and clear valid when the last result drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_out   <= '0;
      res_flags <= '0;
    end else if (fire) begin
      res_valid <= 1'b1;
      res_out   <= alu_out;
      res_flags <= {alu_overflow, alu_parity, alu_sign, alu_carry, alu_zero};
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  // Saturating counters for issued operations and for operations that overflowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_ovf <= '0;
    end else if (fire) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (alu_overflow && (stat_ovf != 16'hFFFF)) stat_ovf <= stat_ovf + 16'd1;
    end
  end
`else
  assign stat_ops = 16'h0000;
  assign stat_ovf = 16'h0000;
`endif

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream issue stage for the combinational ALU.
- Buffers operand/opcode commands in a small FIFO and drives the ALU a/b/select inputs from the FIFO head.
- Registers the ALU result and the five flags (zero, carry, sign, parity, overflow) into an output stage.
- Both sides use valid/ready handshakes, so producer and consumer can stall independently.

Parameters:
- W, 4, operand and result width in bits.
- DEPTH, 4, command FIFO depth in entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- cmd_valid  input  1  command present on cmd_a/cmd_b/cmd_select.
- cmd_ready  output  1  FIFO can accept a command this cycle.
- cmd_a  input  W  operand a.
- cmd_b  input  W  operand b.
- cmd_select  input  2  ALU operation select, passed through unchanged.
- alu_a  output  W  to ALU a.
- alu_b  output  W  to ALU b.
- alu_select  output  2  to ALU select.
- alu_out  input  W  ALU result.
- alu_zero, alu_carry, alu_sign, alu_parity, alu_overflow  input  1 each  ALU flags.
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  consumer accepts the result this cycle.
- res_out  output  W  registered result.
- res_flags  output  5  registered flags {overflow, parity, sign, carry, zero}.
- fifo_level  output  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and level are 0.
  - res_valid, res_out and res_flags are 0.
  - cmd_ready is 1 once rst_n is high.
  - Reset mid-operation discards all queued commands and any held result; nothing is replayed.
- Push: cmd_valid && cmd_ready at a rising edge writes {cmd_a, cmd_b, cmd_select} at the write pointer.
- Ready: cmd_ready = (fifo_level != DEPTH). It is purely registered-state based and has no combinational dependence on res_ready.
- Full: no write-through; a push is refused even if a pop happens in the same cycle.
- ALU drive:
  - FIFO non-empty: alu_a, alu_b and alu_select are combinational from the head entry.
  - FIFO empty: alu_a, alu_b and alu_select are driven to 0.
- Capture condition: fire = (fifo_level != 0) && (!res_valid || res_ready).
  - On fire, res_out <= alu_out and res_flags <= the five ALU flags.
  - res_valid <= 1 and the head is popped.
- Drain: res_valid && res_ready && FIFO empty clears res_valid; res_out and res_flags hold their last values.
- Stall: res_valid && !res_ready holds res_out, res_flags and the FIFO head stable.
- Latency: a command pushed at edge N appears on res_out after edge N+1 at the earliest (one cycle through the FIFO plus capture). Throughput is one result per cycle with res_ready held high.
- Simultaneous push and pop on a non-full, non-empty FIFO: level unchanged, both pointers advance.
- Pointers are clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; the MSB distinguishes full from empty.
- fifo_level = wr_ptr - rd_ptr, truncated to the pointer width.
- Ordering: results leave strictly in command order; no reordering and no drops.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- Defined: adds outputs stat_ops[15:0] and stat_ovf[15:0].
  - stat_ops increments on every fire.
  - stat_ovf increments on every fire with alu_overflow = 1.
  - Both counters saturate at 16'hFFFF and reset to 0 with rst_n.
- Undefined: both ports still exist but are tied to 16'h0000 and no counter logic is built, keeping the port list stable.

Test Plan:
- Reset and single op: rst_n low 3 cycles, then push a=4'h3, b=4'h5, select=2'b00, bench ALU model returns a+b. Required: res_valid=1 two edges after reset release plus push, res_out=4'h8, res_flags=5'b00000 (8 has odd parity, so the parity flag follows the bench model convention).
- Fill and stall: res_ready=0, push 5 commands back-to-back. Required: first is captured; the next 4 fill the FIFO; cmd_ready=0 with fifo_level=4; the 5th is held off and accepted only after res_ready rises.
- Streaming: res_ready=1, push 8 commands a=i, b=1 on consecutive cycles. Required: one result per cycle, res_out=i+1 in order; fifo_level never exceeds 1.
- Wrap-around: push and pop 2*DEPTH+3 = 11 commands with random stalls on both sides. Required: results match a scoreboard in order, and full/empty are reported correctly across the pointer wrap.
- Reset mid-operation: 3 commands queued, res_valid=1, res_ready=0, then pulse rst_n low between edges. Required: res_valid and fifo_level drop to 0 immediately (asynchronously), and no stale result appears after release.
- Stats (ALU_ISSUE_STATS_EN defined): 10 ops with the bench model asserting overflow on 3 of them. Required: stat_ops=10 and stat_ovf=3. With the macro undefined, both read 0.
